// File: rtl/register_file.sv
// Register file: fifteen general registers R0..R14 with two combinational
// read ports and one clocked write port. Address 15 has no storage. Reads at
// address 15 return the externally supplied R15 value (PC+8).
module register_file #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       RA1,
  input  logic [3:0]       RA2,
  input  logic [3:0]       RA3,
  input  logic [WIDTH-1:0] WD3,
  input  logic [WIDTH-1:0] R15,
  input  logic             WE3,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2
);

  localparam logic [3:0] PC_ADDR = 4'd15;

  logic [WIDTH-1:0] regs [0:14];

  // Synchronous clear wins over a same-edge write; writes to address 15 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= '0;
      end
    end else if (WE3 && (RA3 != PC_ADDR)) begin
      regs[RA3] <= WD3;
    end
  end

  // Read port 1: no write bypass, so a same-cycle write is only visible after the edge.
  always_comb begin
    RD1 = R15;
    if (RA1 != PC_ADDR) begin
      RD1 = regs[RA1];
    end
  end

  // Read port 2: independent copy of the port 1 decode.
  always_comb begin
    RD2 = R15;
    if (RA2 != PC_ADDR) begin
      RD2 = regs[RA2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, write/read, write enable, R15
// handling, dual-port sweep, same-cycle read, reset priority and sync reset.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [3:0]  RA1, RA2, RA3;
  logic [31:0] WD3, R15;
  logic        WE3;
  logic [31:0] RD1, RD2;

  int total;
  int bad;

  register_file #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .RA1 (RA1),
    .RA2 (RA2),
    .RA3 (RA3),
    .WD3 (WD3),
    .R15 (R15),
    .WE3 (WE3),
    .RD1 (RD1),
    .RD2 (RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_expect_zero(input string tag);
    for (int i = 0; i < 15; i++) begin
      RA1 = 4'(i);
      RA2 = 4'(14 - i);
      #1;
      chk({tag, "_rd1"}, RD1, 32'h0);
      chk({tag, "_rd2"}, RD2, 32'h0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0; WE3 = 1'b0;
    RA1 = 4'd0; RA2 = 4'd0; RA3 = 4'd0;
    WD3 = 32'h0; R15 = 32'h0000_0008;
    #2;

    // reset case
    do_reset();
    RA1 = 4'd0; RA2 = 4'd1; #1;
    chk("reset_rd1", RD1, 32'h0);
    chk("reset_rd2", RD2, 32'h0);
    sweep_expect_zero("reset_sweep");
    RA1 = 4'd15; #1;
    chk("reset_r15", RD1, 32'h0000_0008);

    // write then read, with same-cycle read showing the old value
    RA3 = 4'd10; WD3 = 32'h0001_3650; WE3 = 1'b1;
    RA1 = 4'd10; RA2 = 4'd1; #1;
    chk("wr_before_edge", RD1, 32'h0);
    tick();
    WE3 = 1'b0; #1;
    chk("wr_after_edge", RD1, 32'h0001_3650);
    chk("wr_other_port", RD2, 32'h0);

    // write disabled on fresh reset
    do_reset();
    RA3 = 4'd10; WD3 = 32'h0001_3650; WE3 = 1'b0;
    tick();
    RA1 = 4'd10; #1;
    chk("we_off", RD1, 32'h0);

    // R15 is combinational, no edge needed
    R15 = 32'h0000_0008; RA1 = 4'd15; RA2 = 4'd15; #1;
    chk("r15_rd1", RD1, 32'h0000_0008);
    chk("r15_rd2", RD2, 32'h0000_0008);
    R15 = 32'h0000_1234; #1;
    chk("r15_follow", RD2, 32'h0000_1234);

    // write all, checking old value visible before each edge
    for (int i = 0; i < 15; i++) begin
      RA3 = 4'(i); WD3 = 32'h100 + 32'(i); WE3 = 1'b1;
      RA1 = 4'(i); #1;
      chk("wall_old", RD1, 32'h0);
      tick();
      #1;
      chk("wall_new", RD1, 32'h100 + 32'(i));
    end
    WE3 = 1'b0;

    // dual-port sweep
    for (int i = 0; i < 15; i++) begin
      RA1 = 4'(i); RA2 = 4'(14 - i); #1;
      chk("dual_rd1", RD1, 32'h100 + 32'(i));
      chk("dual_rd2", RD2, 32'h100 + 32'(14 - i));
    end
    RA1 = 4'd7; RA2 = 4'd7; #1;
    chk("same_addr_rd1", RD1, 32'h107);
    chk("same_addr_rd2", RD2, 32'h107);

    // write to address 15 is dropped
    R15 = 32'h0000_0008;
    RA3 = 4'd15; WD3 = 32'hDEAD_BEEF; WE3 = 1'b1;
    tick();
    WE3 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      RA1 = 4'(i); #1;
      chk("wr15_keep", RD1, 32'h100 + 32'(i));
    end
    RA1 = 4'd15; #1;
    chk("wr15_r15", RD1, 32'h0000_0008);

    // overwrite one register, neighbours untouched
    RA3 = 4'd3; WD3 = 32'hAAAA_5555; WE3 = 1'b1;
    tick();
    WE3 = 1'b0;
    RA1 = 4'd3; RA2 = 4'd4; #1;
    chk("ovr_r3", RD1, 32'hAAAA_5555);
    chk("ovr_r4", RD2, 32'h104);

    // reset priority, and no asynchronous clear before the edge
    RA3 = 4'd5; WD3 = 32'h0000_ABCD; WE3 = 1'b1;
    tick();
    WE3 = 1'b0;
    RA1 = 4'd5; #1;
    chk("rp_r5_set", RD1, 32'h0000_ABCD);
    rst = 1'b1; WE3 = 1'b1; RA3 = 4'd5; WD3 = 32'h1234_5678; #1;
    chk("rp_no_async", RD1, 32'h0000_ABCD);
    tick();
    rst = 1'b0; WE3 = 1'b0; #1;
    chk("rp_r5_clear", RD1, 32'h0);
    sweep_expect_zero("rp_sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
